// File: rtl/matrix_loader_pkg.sv
// Shared types and sizing helpers for matrix_operand_loader.
// Holds the loader FSM states, the element-counter width function and the run-length width.
package matrix_loader_pkg;

    typedef enum logic [1:0] {
        LOAD_X = 2'd0,
        LOAD_Y = 2'd1,
        RUN    = 2'd2
    } state_t;

    localparam int RUN_CYC_W = 16;

    // Counter must hold every index of the larger matrix plus the cleared value.
    function automatic int cnt_width(input int nx, input int ny);
        int m;
        m = (nx > ny) ? nx : ny;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/matrix_operand_loader.sv
// Packs a streamed X/Y element frame into flat operand buses, then holds start until done.
// Optional LOADER_CLEAR_ON_DONE_EN zeroes X/Y when the array reports done.
module matrix_operand_loader
    import matrix_loader_pkg::*;
#(
    parameter int BITWIDTH  = 8,
    parameter int X_ROW     = 3,
    parameter int XCOL_YROW = 3,
    parameter int Y_COL     = 3
) (
    input  logic                                  sys_clk,
    input  logic                                  sys_rst,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [BITWIDTH-1:0]                   s_data,
    input  logic                                  s_last,
    output logic                                  start,
    input  logic                                  done,
    output logic [BITWIDTH*X_ROW*XCOL_YROW-1:0]   X,
    output logic [BITWIDTH*XCOL_YROW*Y_COL-1:0]   Y,
    output logic                                  busy,
    output logic                                  err_len,
    output logic [RUN_CYC_W-1:0]                  run_cycles
);

    localparam int NX    = X_ROW * XCOL_YROW;
    localparam int NY    = XCOL_YROW * Y_COL;
    localparam int CNT_W = cnt_width(NX, NY);
    localparam logic [CNT_W-1:0] LAST_X = CNT_W'(NX - 1);
    localparam logic [CNT_W-1:0] LAST_Y = CNT_W'(NY - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    start_q, start_d;
    logic                    ready_q, ready_d;
    logic                    err_q, err_d;
    logic [RUN_CYC_W-1:0]    rc_q;
    logic [BITWIDTH*NX-1:0]  x_q;
    logic [BITWIDTH*NY-1:0]  y_q;
    logic                    acc, wr_x, wr_y, clr_on_done;

    function automatic logic [RUN_CYC_W-1:0] sat_inc(input logic [RUN_CYC_W-1:0] v);
        return (v == '1) ? v : v + RUN_CYC_W'(1);
    endfunction

    assign acc  = s_valid && ready_q;
    // An s_last beat that ends the frame early writes nothing.
    assign wr_x = (state_q == LOAD_X) && acc && !s_last;
    assign wr_y = (state_q == LOAD_Y) && acc && ((cnt_q == LAST_Y) || !s_last);

`ifdef LOADER_CLEAR_ON_DONE_EN
    assign clr_on_done = (state_q == RUN) && done;
`else
    assign clr_on_done = 1'b0;
`endif

    // State register; start/s_ready are registered so no input reaches them combinationally.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= LOAD_X;
            cnt_q   <= '0;
            start_q <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            if (state_q == RUN)
                rc_q <= sat_inc(rc_q);
            else if (state_d == RUN)
                rc_q <= '0;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            LOAD_X: begin
                if (acc) begin
                    if (s_last) begin
                        err_d = 1'b1;
                        cnt_d = '0;
                    end else if (cnt_q == LAST_X) begin
                        cnt_d   = '0;
                        state_d = LOAD_Y;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            LOAD_Y: begin
                if (acc) begin
                    if (cnt_q == LAST_Y) begin
                        // The count defines the frame; a missing s_last is flagged but still runs.
                        err_d   = !s_last;
                        cnt_d   = '0;
                        state_d = RUN;
                    end else if (s_last) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = LOAD_X;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            RUN: begin
                if (done)
                    state_d = LOAD_X;
            end
            default: begin
                state_d = LOAD_X;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic (next values of the registered handshake outputs)
    always_comb begin
        start_d = (state_d == RUN);
        ready_d = (state_d != RUN);
    end

    // Element k of an N-element matrix lands at bits [BITWIDTH*(N-k)-1 -: BITWIDTH].
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (clr_on_done) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            for (int k = 0; k < NX; k++)
                if (wr_x && (cnt_q == CNT_W'(k)))
                    x_q[BITWIDTH*(NX-k)-1 -: BITWIDTH] <= s_data;
            for (int k = 0; k < NY; k++)
                if (wr_y && (cnt_q == CNT_W'(k)))
                    y_q[BITWIDTH*(NY-k)-1 -: BITWIDTH] <= s_data;
        end
    end

    assign s_ready    = ready_q;
    assign start      = start_q;
    assign err_len    = err_q;
    assign run_cycles = rc_q;
    assign X          = x_q;
    assign Y          = y_q;
    assign busy       = (state_q != LOAD_X) || (cnt_q != '0);

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Scoreboard bench for matrix_operand_loader: stimulus pushes expected runs, a monitor checks them.
module tb_matrix_operand_loader;

    logic         sys_clk = 1'b0;
    logic         sys_rst;
    logic         s_valid;
    logic         s_ready;
    logic [7:0]   s_data;
    logic         s_last;
    logic         start;
    logic         done;
    logic [71:0]  X;
    logic [71:0]  Y;
    logic         busy;
    logic         err_len;
    logic [15:0]  run_cycles;

    matrix_operand_loader dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .start      (start),
        .done       (done),
        .X          (X),
        .Y          (Y),
        .busy       (busy),
        .err_len    (err_len),
        .run_cycles (run_cycles)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [71:0] x;
        logic [71:0] y;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    localparam logic [71:0] XA = 72'h010203040506070809;
    localparam logic [71:0] YA = 72'h030201060504090807;
    localparam logic [71:0] XB = 72'h111213141516171819;
    localparam logic [71:0] YB = 72'hA0A1A2A3A4A5A6A7A8;
    localparam logic [71:0] XC = 72'hFF00FF00FF00FF00FF;
    localparam logic [71:0] YC = 72'h00FF00FF00FF00FF00;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: a start rise presents the assembled operands, a start fall ends the run.
    logic mon_prev   = 1'b0;
    logic mon_active = 1'b0;
    int   mon_len    = 0;
    exp_t cur;

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            mon_prev   = 1'b0;
            mon_active = 1'b0;
        end else begin
            if (start && !mon_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_start", 72'd1, 72'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("run_X", X, cur.x);
                    chk("run_Y", Y, cur.y);
                    chk("run_err_len", {71'd0, err_len}, {71'd0, cur.err});
                    mon_active = 1'b1;
                    mon_len    = 1;
                end
            end else if (start && mon_prev) begin
                mon_len++;
            end else if (!start && mon_prev && mon_active) begin
                if (cur.cyc >= 0) begin
                    chk("start_len", 72'(mon_len), 72'(cur.cyc));
                    chk("run_cycles", {56'd0, run_cycles}, 72'(cur.cyc));
                end
                mon_active = 1'b0;
            end
            mon_prev = start;
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic l);
        int guard;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        guard   = 0;
        while (!s_ready && guard < 50) begin
            @(posedge sys_clk);
            #1;
            guard++;
        end
        if (!s_ready) chk("s_ready_timeout", 72'd0, 72'd1);
        @(posedge sys_clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // gap inserts an idle cycle after each beat; stray pulses done after beat index stray.
    task automatic send_frame(input logic [71:0] x, input logic [71:0] y,
                              input logic gap, input logic with_last, input int stray);
        logic [7:0] d;
        for (int i = 0; i < 18; i++) begin
            d = (i < 9) ? x[8*(9-i)-1 -: 8] : y[8*(18-i)-1 -: 8];
            if (i == 17) chk("start_before_last", {71'd0, start}, 72'd0);
            send_beat(d, with_last && (i == 17));
            if (i == stray) begin
                done = 1'b1;
                @(posedge sys_clk);
                #1;
                done = 1'b0;
                chk("stray_busy", {71'd0, busy}, 72'd1);
                chk("stray_s_ready", {71'd0, s_ready}, 72'd1);
                chk("stray_start", {71'd0, start}, 72'd0);
            end
            if (gap && i < 17) begin
                @(posedge sys_clk);
                #1;
            end
        end
    endtask

    // Called right after the final beat; done is sampled len edges after start rises.
    task automatic run_for(input int len);
        repeat (len - 1) begin
            @(posedge sys_clk);
            #1;
        end
        done = 1'b1;
        @(posedge sys_clk);
        #1;
        done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'd0;
        s_last  = 1'b0;
        done    = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_s_ready", {71'd0, s_ready}, 72'd0);
        chk("rst_start", {71'd0, start}, 72'd0);
        chk("rst_X", X, 72'd0);
        chk("rst_Y", Y, 72'd0);
        chk("rst_busy", {71'd0, busy}, 72'd0);
        chk("rst_err_len", {71'd0, err_len}, 72'd0);
        chk("rst_run_cycles", {56'd0, run_cycles}, 72'd0);
        @(negedge sys_clk);
        #2 sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("post_rst_s_ready", {71'd0, s_ready}, 72'd1);
        chk("post_rst_busy", {71'd0, busy}, 72'd0);

        // Nominal frame, 5-cycle run
        exp_q.push_back('{XA, YA, 1'b0, 5});
        send_frame(XA, YA, 1'b0, 1'b1, -1);
        chk("run_busy", {71'd0, busy}, 72'd1);
        chk("run_s_ready", {71'd0, s_ready}, 72'd0);
        run_for(5);
        chk("after_done_start", {71'd0, start}, 72'd0);
        chk("after_done_s_ready", {71'd0, s_ready}, 72'd1);
        chk("after_done_run_cycles", {56'd0, run_cycles}, 72'd5);
`ifdef LOADER_CLEAR_ON_DONE_EN
        chk("after_done_X", X, 72'd0);
        chk("after_done_Y", Y, 72'd0);
`else
        chk("after_done_X", X, XA);
        chk("after_done_Y", Y, YA);
`endif

        // Source backpressure, 3-cycle run
        exp_q.push_back('{XA, YA, 1'b0, 3});
        send_frame(XA, YA, 1'b1, 1'b1, -1);
        run_for(3);
        chk("bp_run_cycles", {56'd0, run_cycles}, 72'd3);

        // Early s_last on beat 4 discards the frame
        for (int i = 0; i < 3; i++) send_beat(8'h55, 1'b0);
        send_beat(8'h55, 1'b1);
        chk("early_err_len", {71'd0, err_len}, 72'd1);
        chk("early_busy", {71'd0, busy}, 72'd0);
        chk("early_start", {71'd0, start}, 72'd0);
        @(posedge sys_clk);
        #1;
        chk("early_err_pulse_end", {71'd0, err_len}, 72'd0);
        exp_q.push_back('{XB, YB, 1'b0, 2});
        send_frame(XB, YB, 1'b0, 1'b1, -1);
        run_for(2);

        // Missing s_last still runs; done in the first start cycle gives a 1-cycle run
        exp_q.push_back('{XC, YC, 1'b1, 1});
        send_frame(XC, YC, 1'b0, 1'b0, -1);
        run_for(1);
        chk("min_run_cycles", {56'd0, run_cycles}, 72'd1);

        // Stray done during LOAD_Y is ignored
        exp_q.push_back('{XB, YB, 1'b0, 4});
        send_frame(XB, YB, 1'b0, 1'b1, 10);
        run_for(4);

        // Reset in the middle of a run
        exp_q.push_back('{XA, YA, 1'b0, -1});
        send_frame(XA, YA, 1'b0, 1'b1, -1);
        repeat (2) begin
            @(posedge sys_clk);
            #1;
        end
        sys_rst = 1'b1;
        #1;
        chk("midrun_rst_start", {71'd0, start}, 72'd0);
        chk("midrun_rst_X", X, 72'd0);
        chk("midrun_rst_Y", Y, 72'd0);
        chk("midrun_rst_run_cycles", {56'd0, run_cycles}, 72'd0);
        chk("midrun_rst_s_ready", {71'd0, s_ready}, 72'd0);
        @(negedge sys_clk);
        #2 sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("midrun_post_s_ready", {71'd0, s_ready}, 72'd1);
        chk("midrun_post_busy", {71'd0, busy}, 72'd0);

        repeat (3) @(posedge sys_clk);
        #1;
        chk("pending_runs", 72'(exp_q.size()), 72'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/matrix_operand_loader.md
# matrix_operand_loader

Upstream feeder for `systolic_array_top`. It accepts matrix elements one at a time over a valid/ready stream and packs them into the flat `X` and `Y` operand buses. It then raises `start` and holds it until the array answers with `done`, and measures how long the run took. It sits between the host/DMA element stream and the array, so the array always sees stable, fully assembled operands.

## Interface
- `BITWIDTH`, 8, width of one matrix element.
- `X_ROW`, 3, rows of X.
- `XCOL_YROW`, 3, columns of X, which equals rows of Y.
- `Y_COL`, 3, columns of Y.

Ports:
- `sys_clk`  in  1  single clock; all logic is rising-edge.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `s_valid`  in  1  input element valid.
- `s_ready`  out  1  loader can accept an element.
- `s_data`  in  BITWIDTH  element value.
- `s_last`  in  1  marks the final element of a frame.
- `start`  out  1  run request to the array, level-held.
- `done`  in  1  run complete from the array.
- `X`  out  BITWIDTH*X_ROW*XCOL_YROW  packed X operand.
- `Y`  out  BITWIDTH*XCOL_YROW*Y_COL  packed Y operand.
- `busy`  out  1  high while a frame is loading or running.
- `err_len`  out  1  one-cycle pulse on a frame-length error.
- `run_cycles`  out  16  cycles `start` was high in the last run.

## Operation
- Frame definition:
  - NX = X_ROW*XCOL_YROW and NY = XCOL_YROW*Y_COL.
  - A frame is NX elements of X, then NY elements of Y.
  - Both matrices are row-major.
- Packing order:
  - Element k of a matrix with N elements goes to bits [BITWIDTH*(N-k)-1 -: BITWIDTH].
  - Element (0,0) therefore sits in the MSB byte.
- States:
  - LOAD_X (reset state): `s_ready`=1. Each beat where `s_valid` and `s_ready` are both high stores one element and increments the element counter. After beat NX-1 the state moves to LOAD_Y and the counter clears.
  - LOAD_Y: `s_ready`=1, with the same per-beat handling. After beat NY-1 the state moves to RUN.
  - RUN: `s_ready`=0, `start`=1, and `X`/`Y` are held stable. `run_cycles` counts up from 0, saturating at 16'hFFFF. When `done` is sampled high, the state returns to LOAD_X and `run_cycles` freezes at its final value.
- `busy` = (state != LOAD_X) or (element counter != 0).
- Length errors:
  - `s_last` on any beat other than the final Y beat: pulse `err_len`, discard the partial frame (counter to 0, state to LOAD_X, `X`/`Y` unchanged). No run is issued.
  - Final Y beat without `s_last`: pulse `err_len`, but the frame still runs. Frame length is defined by the count, not by `s_last`.
- `done` seen outside RUN is ignored.
- Reset values: `s_ready`=0 during reset and 1 in the first cycle after it; `start`=0, `X`=0, `Y`=0, `busy`=0, `err_len`=0, `run_cycles`=0, state LOAD_X.

## Timing
- The last Y beat is accepted at edge t. `start`=1 and `s_ready`=0 from edge t onward.
- `run_cycles` increments at every edge from t+1 while in RUN.
- `done` is sampled at edge d. At edge d, `start` goes to 0 and `s_ready` goes to 1. A new beat can be accepted at edge d+1.
- `done` and `start` in the same cycle means a run of length ≥1: `run_cycles` equals d−t.
- There is no combinational path from `s_valid` to `s_ready`, or from `done` to `start`. Both outputs are registered.
- Reset mid-RUN: `start` drops asynchronously, and a partial frame is lost.
- Sustained throughput: one element per cycle while loading.

## Configuration
- `LOADER_CLEAR_ON_DONE_EN`:
  - Defined: at edge d, `X` and `Y` are cleared to 0 along with the `start` deassertion.
  - Undefined: `X` and `Y` keep the last frame until they are overwritten element by element.

## Structure
- Package `matrix_loader_pkg` holds:
  - the state enum (LOAD_X, LOAD_Y, RUN);
  - the function computing counter width as $clog2(max(NX,NY)+1);
  - the `run_cycles` width constant (16).
- No sub-module. Packing is a parameterised indexed part-select write inside a single always block.

## Test plan
- Nominal load and run:
  - Stimulus: defaults, back-to-back beats 1..9 then 3,2,1,6,5,4,9,8,7 with `s_last` on the final beat; `done` returned 5 cycles after `start` rises.
  - Response: `X`=72'h010203040506070809, `Y`=72'h030201060504090807; `start` high for exactly 5 sampled cycles then low; `run_cycles`=5; `s_ready` back to 1.
- Backpressure from the source:
  - Stimulus: `s_valid` toggling 1,0,1,0 across the same frame.
  - Response: identical `X`/`Y`; `start` rises only after the 18th accepted beat.
- Early `s_last`:
  - Stimulus: `s_last` on beat 4.
  - Response: `err_len` high for 1 cycle; no `start`; `busy` 0; a following valid frame completes normally.
- Missing `s_last`:
  - Stimulus: full 18-beat frame without `s_last`.
  - Response: `err_len` pulses at edge t; `start` still asserted.
- Reset and stray `done`:
  - Stimulus: assert `sys_rst` mid-RUN; separately, drive `done`=1 during LOAD_Y.
  - Response: on reset, `start`/`X`/`Y`/`run_cycles` are 0 immediately. The stray `done` is ignored and loading continues.
- Macro `LOADER_CLEAR_ON_DONE_EN`:
  - With the macro: `X`/`Y` read 0 the cycle after `done`.
  - Without the macro: `X`/`Y` retain the frame values.
